// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Brief    : IF/ID and PC control for a 5-stage MIPS pipeline. Detects
//            load-use hazards, HI/LO reads during a busy mult/div unit and
//            taken branches/jumps, and drives stall, bubble and flush
//            controls in the same cycle. Also tracks the mult/div busy window
//            and keeps a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int MD_LATENCY  = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [5:0]             if_id_opcode,
    input  logic [5:0]             if_id_func,
    input  logic [4:0]             if_id_rs,
    input  logic [4:0]             if_id_rt,
    input  logic                   id_ex_mem_read,
    input  logic [4:0]             id_ex_rt,
    input  logic                   branch_taken,
    input  logic                   jump,
    input  logic                   md_start,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   md_busy,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // Observational FSM encoding
    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_lu_stall = 2'd1;
    localparam logic [1:0] c_st_md_wait  = 2'd2;

    // Opcode / function codes of interest
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_fn_mfhi  = 6'h10;
    localparam logic [5:0] c_fn_mflo  = 6'h12;

    // Countdown reload: the unit is busy for MD_LATENCY-1 cycles after issue
    localparam logic [5:0] c_md_reload = 6'(MD_LATENCY - 1);
    localparam logic [5:0] c_md_one    = 6'd1;

    localparam logic [STALL_CNT_W-1:0] c_cnt_one = STALL_CNT_W'(1);
    localparam logic [STALL_CNT_W-1:0] c_cnt_max = '1;

    logic [5:0]             r_md_cnt;
    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_uses_rt;
    logic w_hilo_read;
    logic w_lu;
    logic w_mds;
    logic w_stall;
    logic w_md_busy;

    // Decode of the IF/ID instruction fields
    always_comb begin
        w_uses_rt   = (if_id_opcode == c_op_rtype) || (if_id_opcode == c_op_beq) ||
                      (if_id_opcode == c_op_bne)   || (if_id_opcode == c_op_sw);
        w_hilo_read = (if_id_opcode == c_op_rtype) &&
                      ((if_id_func == c_fn_mfhi) || (if_id_func == c_fn_mflo));
    end

    // Hazard detection; a load into $0 never produces a dependency
    always_comb begin
        w_md_busy = (r_md_cnt != 6'd0);
        w_lu      = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) || (w_uses_rt && (id_ex_rt == if_id_rt)));
        w_mds     = w_hilo_read && w_md_busy;
        w_stall   = w_lu || w_mds;
    end

    // State register for the observational FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: load-use takes priority over the mult/div wait
    always_comb begin
        w_next_state = c_st_run;
        if (w_lu) begin
            w_next_state = c_st_lu_stall;
        end else if (w_mds) begin
            w_next_state = c_st_md_wait;
        end
    end

    // Pipeline controls depend only on live inputs and the countdown;
    // flush is held off during a stall since branch operands are not ready
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (rst_n) begin
            if (w_stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else begin
                if_id_flush  = branch_taken || jump;
            end
        end
    end

    // Mult/div busy countdown; a new issue always restarts the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt <= 6'd0;
        end else if (md_start) begin
            r_md_cnt <= c_md_reload;
        end else if (r_md_cnt != 6'd0) begin
            r_md_cnt <= r_md_cnt - c_md_one;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign md_busy      = w_md_busy;
    assign ctrl_state   = r_state;
    assign stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Brief    : Scoreboard bench for pipeline_hazard_controller (MD_LATENCY=4,
//            STALL_CNT_W=4). Expected outputs come from a reference model and
//            are queued when stimulus is applied, then compared mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       if_id_opcode = '0;
    logic [5:0]       if_id_func = '0;
    logic [4:0]       if_id_rs = '0;
    logic [4:0]       if_id_rt = '0;
    logic             id_ex_mem_read = 1'b0;
    logic [4:0]       id_ex_rt = '0;
    logic             branch_taken = 1'b0;
    logic             jump = 1'b0;
    logic             md_start = 1'b0;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             md_busy;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cycles;

    pipeline_hazard_controller #(
        .MD_LATENCY (MD_LAT),
        .STALL_CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_id_opcode  (if_id_opcode),
        .if_id_func    (if_id_func),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .id_ex_mem_read(id_ex_mem_read),
        .id_ex_rt      (id_ex_rt),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .md_start      (md_start),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .md_busy       (md_busy),
        .ctrl_state    (ctrl_state),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pcw;
        logic       ifw;
        logic       fl;
        logic       bub;
        logic       busy;
        logic [1:0] st;
        logic [3:0] sc;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_cnt = 0;
    int m_state = 0;
    int m_sc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_pc_write"},    32'(pc_write),     32'(e.pcw));
            check({tag, "_if_id_write"}, 32'(if_id_write),  32'(e.ifw));
            check({tag, "_flush"},       32'(if_id_flush),  32'(e.fl));
            check({tag, "_bubble"},      32'(id_ex_bubble), 32'(e.bub));
            check({tag, "_md_busy"},     32'(md_busy),      32'(e.busy));
            check({tag, "_state"},       32'(ctrl_state),   32'(e.st));
            check({tag, "_stall_cnt"},   32'(stall_cycles), 32'(e.sc));
        end
    endtask

    task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic mr, input logic [4:0] exrt,
                         input logic br, input logic j, input logic mds);
        if_id_opcode   = op;
        if_id_func     = fn;
        if_id_rs       = rs;
        if_id_rt       = rt;
        id_ex_mem_read = mr;
        id_ex_rt       = exrt;
        branch_taken   = br;
        jump           = j;
        md_start       = mds;
    endtask

    // One normal cycle: apply inputs, queue model prediction, compare, clock model
    task automatic cyc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                       input logic [4:0] exrt, input logic br, input logic j,
                       input logic mds);
        logic uses_rt, hilo, lu, mdw, stall;
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        apply(op, fn, rs, rt, mr, exrt, br, j, mds);
        uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        hilo    = (op == 6'h00) && ((fn == 6'h10) || (fn == 6'h12));
        lu      = mr && (exrt != 5'd0) && ((exrt == rs) || (uses_rt && (exrt == rt)));
        mdw     = hilo && (m_cnt != 0);
        stall   = lu || mdw;
        e.pcw  = !stall;
        e.ifw  = !stall;
        e.bub  = stall;
        e.fl   = !stall && (br || j);
        e.busy = (m_cnt != 0);
        e.st   = 2'(m_state);
        e.sc   = 4'(m_sc);
        sb.push_back(e);
        #2;
        compare_pop(tag);
        @(posedge clk);
        m_cnt   = mds ? (MD_LAT - 1) : ((m_cnt != 0) ? m_cnt - 1 : 0);
        m_state = lu ? 1 : (mdw ? 2 : 0);
        if (stall && (m_sc != 15)) m_sc = m_sc + 1;
    endtask

    // One cycle with reset held low while hazard-causing inputs are applied
    task automatic rst_cyc();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        apply(6'h00, 6'h12, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1);
        m_cnt = 0; m_state = 0; m_sc = 0;
        e.pcw = 1'b1; e.ifw = 1'b1; e.fl = 1'b0; e.bub = 1'b0;
        e.busy = 1'b0; e.st = 2'd0; e.sc = 4'd0;
        sb.push_back(e);
        #2;
        compare_pop("reset");
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        // Reset state, with hazard inputs active to show outputs are forced
        rst_cyc();
        rst_cyc();

        // Load-use on rs
        cyc("lu_rs", 6'h00, 6'h20, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        cyc("lu_after", 6'h00, 6'h20, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_state_direct", 32'(ctrl_state), 32'd1);
        check("lu_cnt_direct", 32'(stall_cycles), 32'd1);

        // $0 load never stalls; rt-only match on lw does not stall
        cyc("lu_r0", 6'h00, 6'h20, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("lw_rt", 6'h23, 6'h00, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        check("lw_rt_pcw_direct", 32'(pc_write), 32'd1);
        // rt match on rt users does stall
        cyc("rt_rtype", 6'h00, 6'h20, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        cyc("rt_beq",   6'h04, 6'h00, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        cyc("rt_bne",   6'h05, 6'h00, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        cyc("rt_sw",    6'h2B, 6'h00, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        cyc("rt_addi",  6'h08, 6'h00, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);

        // Mult/div wait: md_start then mflo held
        rst_cyc();
        cyc("md_issue", 6'h00, 6'h18, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc("mflo_wait", 6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        end
        check("md_cnt_direct", 32'(stall_cycles), 32'd3);
        check("md_busy_direct", 32'(md_busy), 32'd0);

        // mfhi with back-to-back issue restarts the window
        cyc("md_issue2", 6'h00, 6'h1A, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc("mfhi_reissue", 6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc("mfhi_wait", 6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        end

        // Branch / jump flush and priority against load-use
        cyc("br_flush", 6'h04, 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        check("br_flush_direct", 32'(if_id_flush), 32'd1);
        cyc("jmp_flush", 6'h02, 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("br_lu", 6'h04, 6'h00, 5'd7, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        check("br_lu_flush_direct", 32'(if_id_flush), 32'd0);
        check("br_lu_bubble_direct", 32'(id_ex_bubble), 32'd1);

        // Counter saturation
        rst_cyc();
        for (int i = 0; i < 20; i++) begin
            cyc("sat", 6'h00, 6'h20, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        end
        cyc("sat_idle", 6'h00, 6'h20, 5'd1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("sat_direct", 32'(stall_cycles), 32'd15);

        // Random mix with narrow register range for frequent matches
        rst_cyc();
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            case ($urandom_range(0, 5))
                0: op = 6'h04;
                1: op = 6'h05;
                2: op = 6'h2B;
                3: op = 6'h23;
                default: op = 6'h00;
            endcase
            fn = ($urandom_range(0, 1) == 0) ? 6'h12 : 6'(($urandom_range(0, 3) == 0) ? 6'h10 : 6'h20);
            cyc("rand", op, fn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 7) == 0));
        end

        // Async reset in the middle of a mult/div wait
        rst_cyc();
        cyc("ar_issue", 6'h00, 6'h18, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc("ar_wait", 6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("ar_wait", 6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        m_cnt = 0; m_state = 0; m_sc = 0;
        e.pcw = 1'b1; e.ifw = 1'b1; e.fl = 1'b0; e.bub = 1'b0;
        e.busy = 1'b0; e.st = 2'd0; e.sc = 4'd0;
        sb.push_back(e);
        #1;
        compare_pop("async_rst");
        @(posedge clk);
        // mflo still held after release: no stall since the countdown cleared
        cyc("ar_release", 6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("ar_release", 6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Controls the IF/ID pipeline register and the PC for the 5-stage MIPS pipeline.
- Detects three conditions and drives write-enable, flush and bubble controls in the same cycle:
  - load-use hazards;
  - HI/LO reads while the multi-cycle multiply/divide unit is busy;
  - taken branches or jumps resolved in ID.
- Tracks the multiply/divide busy window with an internal countdown.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
MD_LATENCY, 32, cycles the mult/div unit occupies after issue (valid range 2..63)
STALL_CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_id_opcode  input  6  opcode of the instruction held in IF/ID
if_id_func  input  6  function field of the instruction held in IF/ID
if_id_rs  input  5  rs field of the instruction held in IF/ID
if_id_rt  input  5  rt field of the instruction held in IF/ID
id_ex_mem_read  input  1  instruction in EX is a load
id_ex_rt  input  5  destination register of the load in EX
branch_taken  input  1  branch in ID resolved taken (beq/bne)
jump  input  1  j/jal/jr decoded in ID
md_start  input  1  mult/multu/div/divu issued into EX this cycle
pc_write  output  1  PC update enable
if_id_write  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID register loads a nop at the next edge
id_ex_bubble  output  1  zero control signals into ID/EX
md_busy  output  1  mult/div countdown is nonzero
ctrl_state  output  2  FSM state: 0 RUN, 1 LU_STALL, 2 MD_WAIT
stall_cycles  output  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst_n low, asynchronous):
  - ctrl_state = RUN, md countdown = 0, stall_cycles = 0.
  - Outputs during reset: pc_write = 1, if_id_write = 1, if_id_flush = 0, id_ex_bubble = 0, md_busy = 0.
- Decode, combinational, from the IF/ID fields:
  - uses_rt = 1 for opcode 0 (R-type), 4 (beq), 5 (bne), 0x2B (sw).
  - hilo_read = 1 when opcode 0 and func is 0x10 (mfhi) or 0x12 (mflo).
- Hazard conditions, combinational, evaluated in the current cycle (zero latency):
  - lu = id_ex_mem_read & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (uses_rt & id_ex_rt == if_id_rt)).
  - mds = hilo_read & md_busy.
  - stall = lu | mds.
- Output rules when stall = 1:
  - pc_write = 0, if_id_write = 0, id_ex_bubble = 1, if_id_flush = 0.
  - Flush is suppressed because the branch operands are not yet valid.
- Output rules when stall = 0:
  - pc_write = 1, if_id_write = 1, id_ex_bubble = 0.
  - if_id_flush = branch_taken | jump.
- Priority: lu over mds over flush.
- Mult/div countdown (6-bit):
  - md_start with countdown = 0: load MD_LATENCY-1 at the next edge.
  - md_start while countdown != 0: reload MD_LATENCY-1 (back-to-back issue restarts the window).
  - Otherwise the countdown decrements while nonzero.
  - md_busy = (countdown != 0), registered view.
- FSM, next state at each rising edge:
  - next = LU_STALL if lu; else MD_WAIT if mds; else RUN.
  - ctrl_state is observational only. Outputs never depend on ctrl_state, only on the current inputs and the countdown.
- stall_cycles: increments by 1 at each edge where stall = 1. Saturates at all-ones with no wrap.
- Simultaneous events:
  - md_start together with mds in the same cycle: the stall uses the current countdown value; the reload takes effect next cycle.
  - lu together with branch_taken: stall; no flush.
- Register 0: a load targeting $0 never causes a stall.
- Reset mid-stall: all state clears immediately; the first cycle after rst_n rises is RUN with no stall unless the inputs demand one.

Test Plan:
- Load-use on rs: id_ex_mem_read = 1, id_ex_rt = 8, if_id_rs = 8, opcode 0 -> pc_write = 0, if_id_write = 0, id_ex_bubble = 1 that cycle; ctrl_state = 1 next cycle; stall_cycles = 1.
- Load to $0 / rt-only match on a non-rt user: id_ex_rt = 0 with if_id_rs = 0 -> no stall. Then id_ex_rt = 9, if_id_rt = 9, opcode 0x23 (lw) -> no stall.
- Mult/div wait: md_start pulse with MD_LATENCY = 4, then mflo (opcode 0, func 0x12) held in ID -> stall for 3 cycles while md_busy = 1; released on the cycle md_busy falls; stall_cycles = 3.
- Branch flush and priority: branch_taken = 1 with no hazard -> if_id_flush = 1, pc_write = 1. Same cycle with lu = 1 -> if_id_flush = 0, id_ex_bubble = 1.
- Counter saturation: STALL_CNT_W = 4, hold lu for 20 cycles -> stall_cycles stops at 15.
- Async reset mid-MD_WAIT: drop rst_n between edges -> md_busy = 0, ctrl_state = 0, stall_cycles = 0 immediately; pc_write = 1.
